// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: ALU control codes, RV32I opcodes and the issue beat.
package alu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7,
    ALU_SRA = 4'd8
  } alu_ctl_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    alu_ctl_e        ctl;
    logic [4:0]      shamt;
    logic [4:0]      rd;
    logic            wb_en;
    logic            illegal;
  } issue_beat_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Handshake and operand bundle between register read, the issue stage and execute.
interface alu_issue_stage_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  flush_i;
  logic                  valid_i;
  logic                  ready_o;
  logic [31:0]           instr_i;
  logic [DATA_WIDTH-1:0] pc_i;
  logic [DATA_WIDTH-1:0] rs1_data_i;
  logic [DATA_WIDTH-1:0] rs2_data_i;
  logic                  valid_o;
  logic                  ready_i;
  logic [DATA_WIDTH-1:0] a_o;
  logic [DATA_WIDTH-1:0] b_o;
  logic [3:0]            ctl_o;
  logic [4:0]            shamt_o;
  logic [4:0]            rd_o;
  logic                  wb_en_o;
  logic                  illegal_o;

  modport slave (
    input  flush_i, valid_i, instr_i, pc_i, rs1_data_i, rs2_data_i, ready_i,
    output ready_o, valid_o, a_o, b_o, ctl_o, shamt_o, rd_o, wb_en_o, illegal_o
  );

  modport master (
    output flush_i, valid_i, instr_i, pc_i, rs1_data_i, rs2_data_i, ready_i,
    input  ready_o, valid_o, a_o, b_o, ctl_o, shamt_o, rd_o, wb_en_o, illegal_o
  );
endinterface

// File: rtl/alu_decode.sv
// Combinational RV32I decoder for OP, OP-IMM, LUI and AUIPC into an ALU issue beat.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output issue_beat_t     beat_o
);

  logic [6:0]      opcode, f7;
  logic [2:0]      f3;
  logic [4:0]      rd;
  logic            f7_zero, f7_alt;
  logic [XLEN-1:0] imm_i, imm_u;

  logic            legal;
  alu_ctl_e        ctl;
  logic [XLEN-1:0] a, b;
  logic [4:0]      shamt;

  assign opcode  = instr_i[6:0];
  assign rd      = instr_i[11:7];
  assign f3      = instr_i[14:12];
  assign f7      = instr_i[31:25];
  assign f7_zero = (f7 == F7_ZERO);
  assign f7_alt  = (f7 == F7_ALT);
  assign imm_i   = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
  assign imm_u   = {instr_i[31:12], 12'b0};

  always_comb begin
    legal = 1'b0;
    ctl   = ALU_ADD;
    a     = '0;
    b     = '0;
    shamt = '0;
    case (opcode)
      OPC_OP: begin
        a     = rs1_data_i;
        b     = rs2_data_i;
        shamt = rs2_data_i[4:0];
        unique case (f3)
          3'b000: begin ctl = f7_alt ? ALU_SUB : ALU_ADD; legal = f7_zero || f7_alt; end
          3'b001: begin ctl = ALU_SLL; legal = f7_zero; end
          3'b010: begin ctl = ALU_SLT; legal = f7_zero; end
          3'b011: legal = 1'b0;
          3'b100: begin ctl = ALU_XOR; legal = f7_zero; end
          3'b101: begin ctl = f7_alt ? ALU_SRA : ALU_SRL; legal = f7_zero || f7_alt; end
          3'b110: begin ctl = ALU_OR;  legal = f7_zero; end
          3'b111: begin ctl = ALU_AND; legal = f7_zero; end
        endcase
      end
      OPC_OP_IMM: begin
        a     = rs1_data_i;
        b     = imm_i;
        shamt = instr_i[24:20];
        // Only the shift-immediates constrain the upper bits of the immediate.
        unique case (f3)
          3'b000: begin ctl = ALU_ADD; legal = 1'b1; end
          3'b001: begin ctl = ALU_SLL; legal = f7_zero; end
          3'b010: begin ctl = ALU_SLT; legal = 1'b1; end
          3'b011: legal = 1'b0;
          3'b100: begin ctl = ALU_XOR; legal = 1'b1; end
          3'b101: begin ctl = f7_alt ? ALU_SRA : ALU_SRL; legal = f7_zero || f7_alt; end
          3'b110: begin ctl = ALU_OR;  legal = 1'b1; end
          3'b111: begin ctl = ALU_AND; legal = 1'b1; end
        endcase
      end
      OPC_LUI: begin
        b     = imm_u;
        legal = 1'b1;
      end
      OPC_AUIPC: begin
        a     = pc_i;
        b     = imm_u;
        legal = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    beat_o         = '0;
    beat_o.rd      = rd;
    beat_o.illegal = !legal;
    beat_o.wb_en   = legal && (rd != 5'd0);
    if (legal) begin
      beat_o.a     = a;
      beat_o.b     = b;
      beat_o.ctl   = ctl;
      beat_o.shamt = shamt;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue pipeline register in front of the ALU with valid/ready on both sides.
// Define ALU_ISSUE_SKID_EN to add a one-entry skid buffer and register ready_o.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic              clk_i,
  input logic              rst_i,
  alu_issue_stage_if.slave bus
);

  localparam issue_beat_t BeatReset = '0;

  issue_beat_t dec_beat;
  issue_beat_t out_d, out_q;
  logic        valid_d, valid_q;
  logic        ready;
  logic        load;

  alu_decode u_decode (
    .instr_i    (bus.instr_i),
    .pc_i       (bus.pc_i),
    .rs1_data_i (bus.rs1_data_i),
    .rs2_data_i (bus.rs2_data_i),
    .beat_o     (dec_beat)
  );

`ifdef ALU_ISSUE_SKID_EN
  issue_beat_t skid_d, skid_q;
  logic        skid_valid_d, skid_valid_q;

  // Accept only into an empty skid slot; this breaks the ready_i -> ready_o path.
  assign ready = !skid_valid_q;
  assign load  = bus.valid_i && ready;

  always_comb begin
    out_d        = out_q;
    valid_d      = valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (!valid_q || bus.ready_i) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        valid_d      = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        valid_d = load;
        if (load) out_d = dec_beat;
      end
    end else if (load) begin
      skid_d       = dec_beat;
      skid_valid_d = 1'b1;
    end
    if (bus.flush_i) begin
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q        <= BeatReset;
      valid_q      <= 1'b0;
      skid_q       <= BeatReset;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      valid_q      <= valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end
`else
  assign ready = !valid_q || bus.ready_i;
  assign load  = bus.valid_i && ready;

  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    if (bus.flush_i) begin
      valid_d = 1'b0;
    end else if (load) begin
      out_d   = dec_beat;
      valid_d = 1'b1;
    end else if (bus.ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q   <= BeatReset;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end
`endif

  assign bus.ready_o   = ready;
  assign bus.valid_o   = valid_q;
  assign bus.a_o       = DATA_WIDTH'(out_q.a);
  assign bus.b_o       = DATA_WIDTH'(out_q.b);
  assign bus.ctl_o     = out_q.ctl;
  assign bus.shamt_o   = out_q.shamt;
  assign bus.rd_o      = out_q.rd;
  assign bus.wb_en_o   = out_q.wb_en;
  assign bus.illegal_o = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed decode, stall/flush and a random stream.
module tb_alu_issue_stage;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctl;
    logic [4:0]  shamt;
    logic [4:0]  rd;
    logic        wb_en;
    logic        illegal;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  alu_issue_stage_if #(.DATA_WIDTH(32)) bus ();

  alu_issue_stage #(.DATA_WIDTH(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Reference decode straight from the ISA tables.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    int   base_ctl [8];
    int   op, f3, f7;
    bit   ok, alt;
    base_ctl = '{0, 6, 5, 0, 4, 7, 3, 2};
    op  = int'(ins[6:0]);
    f3  = int'(ins[14:12]);
    f7  = int'(ins[31:25]);
    alt = (f7 == 32);
    ok  = 1'b0;
    e   = '0;
    e.rd = ins[11:7];
    if (op == 'h33) begin
      e.a     = r1;
      e.b     = r2;
      e.shamt = r2[4:0];
      ok      = (f3 != 3) && ((f7 == 0) || (alt && (f3 == 0 || f3 == 5)));
      e.ctl   = 4'(base_ctl[f3]);
      if (alt && f3 == 0) e.ctl = 4'd1;
      if (alt && f3 == 5) e.ctl = 4'd8;
    end else if (op == 'h13) begin
      e.a     = r1;
      e.b     = 32'($signed(ins[31:20]));
      e.shamt = ins[24:20];
      if (f3 == 3)      ok = 1'b0;
      else if (f3 == 1) ok = (f7 == 0);
      else if (f3 == 5) ok = (f7 == 0) || alt;
      else              ok = 1'b1;
      e.ctl = 4'(base_ctl[f3]);
      if (alt && f3 == 5) e.ctl = 4'd8;
    end else if (op == 'h37) begin
      e.b = ins & 32'hFFFF_F000;
      ok  = 1'b1;
    end else if (op == 'h17) begin
      e.a = pc;
      e.b = ins & 32'hFFFF_F000;
      ok  = 1'b1;
    end
    if (!ok) begin
      e.a     = '0;
      e.b     = '0;
      e.ctl   = '0;
      e.shamt = '0;
    end
    e.illegal = !ok;
    e.wb_en   = ok && (e.rd != 0);
    return e;
  endfunction

  task automatic step(input bit v, input bit rdy, input bit fl, input bit rs,
                      input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] r1, input logic [31:0] r2);
    @(posedge clk);
    #1;
    rst            = rs;
    bus.flush_i    = fl;
    bus.valid_i    = v;
    bus.ready_i    = rdy;
    bus.instr_i    = ins;
    bus.pc_i       = pc;
    bus.rs1_data_i = r1;
    bus.rs2_data_i = r2;
    @(negedge clk);
    if (rs || fl) q.delete();
    else if (v && bus.ready_o) q.push_back(ref_decode(ins, pc, r1, r2));
  endtask

  // Monitor: protocol checks plus in-order comparison against the scoreboard.
  bit          prev_rst = 1'b0, prev_flush = 1'b0, prev_hold = 1'b0;
  logic [80:0] snap;
  always @(negedge clk) begin
    logic [80:0] cur;
    logic [79:0] got;
    exp_t        e;
    cur = {bus.valid_o, bus.a_o, bus.b_o, bus.ctl_o, bus.shamt_o, bus.rd_o,
           bus.wb_en_o, bus.illegal_o};
    got = cur[79:0];
    if (prev_rst) begin
      checks++;
      if (cur !== 81'd0 || bus.ready_o !== 1'b1) begin
        errors++;
        $display("FAIL reset_values got=%h ready=%b exp=0 ready=1", cur, bus.ready_o);
      end
    end else if (prev_flush) begin
      checks++;
      if (bus.valid_o !== 1'b0) begin
        errors++;
        $display("FAIL flush_valid got=%b exp=0", bus.valid_o);
      end
    end
    if (prev_hold) begin
      checks++;
      if (cur !== snap) begin
        errors++;
        $display("FAIL stall_stable got=%h exp=%h", cur, snap);
      end
    end
`ifdef ALU_ISSUE_SKID_EN
    if (!rst && !bus.valid_o) begin
      checks++;
      if (bus.ready_o !== 1'b1) begin
        errors++;
        $display("FAIL ready_when_empty got=%b exp=1", bus.ready_o);
      end
    end
`else
    if (!rst) begin
      checks++;
      if (bus.ready_o !== (!bus.valid_o || bus.ready_i)) begin
        errors++;
        $display("FAIL ready_rule got=%b exp=%b", bus.ready_o, !bus.valid_o || bus.ready_i);
      end
    end
`endif
    if (bus.valid_o === 1'b1 && bus.ready_i === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL extra_beat got=%h exp=none", got);
      end else begin
        e = q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL beat got=%h exp=%h", got, e);
        end
      end
    end
    prev_rst   = rst;
    prev_flush = bus.flush_i;
    prev_hold  = bus.valid_o && !bus.ready_i && !rst && !bus.flush_i;
    snap       = cur;
  end

  initial begin
    logic [31:0] ins;
    logic [6:0]  opcs [5];
    bit          v, rdy, fl, rs;
    opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h7F};
    bus.flush_i = 1'b0; bus.valid_i = 1'b0; bus.ready_i = 1'b0;
    bus.instr_i = '0; bus.pc_i = '0; bus.rs1_data_i = '0; bus.rs2_data_i = '0;

    step(0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);

    step(1, 1, 0, 0, 32'h0020_81B3, 32'h0, 32'd5, 32'd7);          // ADD x3,x1,x2
    step(1, 1, 0, 0, 32'h4043_5293, 32'h4, 32'h8000_0000, 32'd0);  // SRAI x5,x6,4
    step(1, 1, 0, 0, 32'h1234_5097, 32'h100, 32'd1, 32'd2);        // AUIPC x1,0x12345
    step(1, 1, 0, 0, 32'h0020_B1B3, 32'h8, 32'd9, 32'd9);          // SLTU
    step(1, 1, 0, 0, 32'h0000_007F, 32'hC, 32'd9, 32'd9);          // unknown opcode

    // Stall with valid held, then release; then stall again and flush.
    step(1, 0, 0, 0, 32'h0020_81B3, 32'h10, 32'd1, 32'd2);
    step(1, 0, 0, 0, 32'h4020_81B3, 32'h14, 32'd3, 32'd4);
    step(1, 0, 0, 0, 32'h0020_C1B3, 32'h18, 32'd5, 32'd6);
    step(1, 1, 0, 0, 32'h0020_E1B3, 32'h1C, 32'd7, 32'd8);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 32'h0010_0093, 32'h20, 32'd1, 32'd0);
    step(1, 0, 0, 0, 32'h0020_0113, 32'h24, 32'd1, 32'd0);
    step(1, 0, 1, 0, 32'h0030_0193, 32'h28, 32'd1, 32'd0);
    step(0, 1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 1000; i++) begin
      ins = $urandom;
      ins[6:0] = opcs[$urandom_range(4)];
      case ($urandom_range(3))
        0: ins[31:25] = 7'h00;
        1: ins[31:25] = 7'h20;
        default: ;
      endcase
      rs  = ($urandom_range(99) == 0);
      fl  = !rs && ($urandom_range(49) == 0);
      v   = ($urandom_range(3) != 0);
      rdy = !rs && !fl && ($urandom_range(9) < 7);
      step(v, rdy, fl, rs, ins, $urandom & 32'hFFFF_FFFC, $urandom, $urandom);
    end

    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending exp=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
